// File: rtl/ldst_burst_scheduler_pkg.sv
// Shared types and the AXI burst-split helper for the global load/store path.
package ldst_burst_scheduler_pkg;

  localparam int unsigned AxiDataWidth   = 512;
  localparam int unsigned AxiAddrWidth   = 64;
  localparam int unsigned VlWidth        = 16;
  localparam int unsigned MaxAxiBurst    = 256;
  localparam int unsigned PageOffsetBits = 12;
  localparam int unsigned BeatBytes      = AxiDataWidth / 8;

  typedef enum logic [1:0] {IDLE, SPLIT, DRAIN} state_e;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] aligned_addr;
    logic [7:0]              len;
    logic [VlWidth-1:0]      vl_done;
    logic [AxiAddrWidth-1:0] next_addr;
  } burst_split_t;

  typedef struct packed {
    logic                    is_store;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [VlWidth-1:0]      vl;
    logic                    last;
  } ldst_burst_t;

  // Largest legal INCR burst starting at addr: beat-aligned, within one 4 KiB page.
  function automatic burst_split_t burst_split(input logic [AxiAddrWidth-1:0] addr,
                                               input logic [VlWidth-1:0]      vl,
                                               input logic [1:0]              vew);
    logic [AxiAddrWidth-1:0] bytes, start, nxt, nxt_m1, beats;
    burst_split_t res;
    bytes  = AxiAddrWidth'(vl) << vew;
    start  = addr & ~AxiAddrWidth'(BeatBytes - 1);
    nxt    = ((addr + bytes - 1) & ~AxiAddrWidth'(BeatBytes - 1)) + AxiAddrWidth'(BeatBytes);
    nxt_m1 = nxt - 1;
    if ((start >> PageOffsetBits) != (nxt_m1 >> PageOffsetBits))
      nxt = ((start >> PageOffsetBits) + 1) << PageOffsetBits;
    beats = (nxt - start) / AxiAddrWidth'(BeatBytes);
    if (beats > AxiAddrWidth'(MaxAxiBurst)) begin
      beats = AxiAddrWidth'(MaxAxiBurst);
      nxt   = start + AxiAddrWidth'(MaxAxiBurst * BeatBytes);
    end
    res.aligned_addr = start;
    res.len          = 8'(beats - 1);
    res.vl_done      = VlWidth'((nxt - addr) >> vew);
    res.next_addr    = nxt;
    return res;
  endfunction

endpackage

// File: rtl/ldst_burst_scheduler.sv
// Splits a vector memory command into AXI INCR bursts and tracks in-flight
// bursts with a credit counter until the command fully retires.
module ldst_burst_scheduler
  import ldst_burst_scheduler_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_is_store_i,
  input  logic [AxiAddrWidth-1:0] cmd_addr_i,
  input  logic [VlWidth-1:0]      cmd_vl_i,
  input  logic [1:0]              cmd_vew_i,
  output logic                    burst_valid_o,
  input  logic                    burst_ready_i,
  output logic                    burst_is_store_o,
  output logic [AxiAddrWidth-1:0] burst_addr_o,
  output logic [7:0]              burst_len_o,
  output logic [VlWidth-1:0]      burst_vl_o,
  output logic                    burst_last_o,
  input  logic                    r_last_i,
  input  logic                    b_valid_i,
  output logic                    busy_o,
  output logic                    cmd_done_o,
  output logic [CntW-1:0]         outstanding_o,
  output logic                    err_o
);

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [VlWidth-1:0]      rem_q;
  logic [1:0]              vew_q;
  logic                    is_store_q;
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;
  burst_split_t            sp;
  ldst_burst_t             burst;
  logic                    accept, hs, retire;

  assign sp     = burst_split(addr_q, rem_q, vew_q);
  assign accept = cmd_valid_i & cmd_ready_o;
  assign hs     = burst_valid_o & burst_ready_i;
  // Only the channel of the current command retires bursts.
  assign retire = is_store_q ? b_valid_i : r_last_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (cmd_vl_i == '0) ? DRAIN : SPLIT;
      SPLIT:   if (hs && burst_last_o) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o    = 1'b0;
    burst_valid_o  = 1'b0;
    cmd_done_o     = 1'b0;
    burst          = '0;
    case (state_q)
      IDLE:  cmd_ready_o = 1'b1;
      SPLIT: begin
        burst_valid_o  = cnt_q < CntW'(MaxOutstanding);
        burst.is_store = is_store_q;
        burst.addr     = sp.aligned_addr;
        burst.len      = sp.len;
        burst.last     = rem_q <= sp.vl_done;
        burst.vl       = burst.last ? rem_q : sp.vl_done;
      end
      DRAIN: cmd_done_o = cnt_q == '0;
      default: ;
    endcase
  end

  assign burst_is_store_o = burst.is_store;
  assign burst_addr_o     = burst.addr;
  assign burst_len_o      = burst.len;
  assign burst_vl_o       = burst.vl;
  assign burst_last_o     = burst.last;
  assign busy_o           = state_q != IDLE;
  assign outstanding_o    = cnt_q;
  assign err_o            = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      rem_q      <= '0;
      vew_q      <= '0;
      is_store_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= cmd_addr_i;
      rem_q      <= cmd_vl_i;
      vew_q      <= cmd_vew_i;
      is_store_q <= cmd_is_store_i;
    end else if (hs && !burst_last_o) begin
      addr_q <= sp.next_addr;
      rem_q  <= rem_q - sp.vl_done;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case ({hs, retire})
        2'b10: cnt_q <= cnt_q + 1'b1;
        2'b01: if (cnt_q == '0) err_q <= 1'b1;
               else             cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_burst_scheduler.sv
// Randomized bench: expected bursts come from a byte-range model of the split rules.
module tb_ldst_burst_scheduler;

  localparam int MaxOut = 2;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_is_store_i = 1'b0;
  logic [63:0] cmd_addr_i = '0;
  logic [15:0] cmd_vl_i = '0;
  logic [1:0]  cmd_vew_i = '0;
  logic        burst_valid_o, burst_ready_i = 1'b0, burst_is_store_o;
  logic [63:0] burst_addr_o;
  logic [7:0]  burst_len_o;
  logic [15:0] burst_vl_o;
  logic        burst_last_o, r_last_i = 1'b0, b_valid_i = 1'b0;
  logic        busy_o, cmd_done_o, err_o;
  logic [1:0]  outstanding_o;

  ldst_burst_scheduler #(.MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_is_store_i(cmd_is_store_i),
    .cmd_addr_i(cmd_addr_i), .cmd_vl_i(cmd_vl_i), .cmd_vew_i(cmd_vew_i),
    .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
    .burst_is_store_o(burst_is_store_o), .burst_addr_o(burst_addr_o),
    .burst_len_o(burst_len_o), .burst_vl_o(burst_vl_o), .burst_last_o(burst_last_o),
    .r_last_i(r_last_i), .b_valid_i(b_valid_i), .busy_o(busy_o),
    .cmd_done_o(cmd_done_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  longint unsigned q_addr[$];
  int              q_len[$], q_vl[$];
  bit              q_last[$];

  // Each burst ends at the earliest of: data end (rounded to a beat), page end, 256 beats.
  task automatic gen(input longint unsigned a0, input int vl, input int vew);
    longint unsigned a, r, start, lim, pe, vd;
    q_addr.delete(); q_len.delete(); q_vl.delete(); q_last.delete();
    a = a0; r = vl;
    while (r > 0) begin
      start = a - (a % 64);
      lim   = ((a + (r << vew) + 63) / 64) * 64;
      pe    = (a / 4096 + 1) * 4096;
      if (pe < lim) lim = pe;
      if ((lim - start) / 64 > 256) lim = start + 256 * 64;
      vd = ((lim - a) >> vew) & 64'hFFFF;
      q_addr.push_back(start);
      q_len.push_back(int'((lim - start) / 64) - 1);
      if (r > vd) begin
        q_vl.push_back(int'(vd)); q_last.push_back(1'b0);
        a = lim; r = r - vd;
      end else begin
        q_vl.push_back(int'(r)); q_last.push_back(1'b1);
        r = 0;
      end
    end
  endtask

  // Called at posedge+#1 with the scheduler idle; returns at posedge+#1 after done.
  task automatic run_cmd(input bit st, input longint unsigned addr, input int vl, input int vew);
    int  mcnt = 0, idx = 0, cyc = 0;
    bit  drain, done_seen = 0, exp_valid, exp_done, hs, right, wrong;
    gen(addr, vl, vew);
    cmd_valid_i = 1'b1; cmd_is_store_i = st; cmd_addr_i = addr;
    cmd_vl_i = 16'(vl); cmd_vew_i = 2'(vew);
    @(negedge clk_i);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    chk("busy_idle", busy_o, 0);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    drain = (vl == 0);
    while (!done_seen && cyc < 5000) begin
      cyc++;
      burst_ready_i = ($urandom_range(0, 3) != 0);
      right = (mcnt > 0) && ($urandom_range(0, 2) == 0);
      wrong = ($urandom_range(0, 3) == 0);
      b_valid_i = st ? right : wrong;
      r_last_i  = st ? wrong : right;
      @(negedge clk_i);
      exp_valid = !drain && (mcnt < MaxOut);
      exp_done  = drain && (mcnt == 0);
      chk("burst_valid", burst_valid_o, exp_valid);
      chk("busy", busy_o, 1);
      chk("cmd_ready_busy", cmd_ready_o, 0);
      chk("outstanding", outstanding_o, mcnt);
      chk("cmd_done", cmd_done_o, exp_done);
      chk("err_quiet", err_o, 0);
      if (exp_valid && burst_valid_o && idx < q_addr.size()) begin
        chk("burst_addr", burst_addr_o, q_addr[idx]);
        chk("burst_len", burst_len_o, q_len[idx]);
        chk("burst_vl", burst_vl_o, q_vl[idx]);
        chk("burst_last", burst_last_o, q_last[idx]);
        chk("burst_is_store", burst_is_store_o, st);
      end
      hs = exp_valid && burst_ready_i;
      mcnt = mcnt + int'(hs) - int'(right);
      if (hs) begin
        if (idx >= q_addr.size() || q_last[idx]) drain = 1;
        idx++;
      end
      if (exp_done) done_seen = 1;
      @(posedge clk_i); #1;
    end
    b_valid_i = 1'b0; r_last_i = 1'b0; burst_ready_i = 1'b0;
    if (!done_seen) chk("cmd_timeout", 0, 1);
    chk("burst_count", idx, q_addr.size());
  endtask

  initial begin
    #2;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_burst_valid", burst_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", cmd_done_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_cmd(0, 64'h1000, 64, 3);
    run_cmd(0, 64'h1010, 16, 2);
    run_cmd(0, 64'h1FC0, 32, 3);
    run_cmd(0, 64'h0, 2048, 3);
    run_cmd(1, 64'h3F00, 100, 2);
    run_cmd(0, 64'h2000, 0, 1);
    for (int i = 0; i < 40; i++) begin
      int vew, vl;
      longint unsigned a;
      vew = $urandom_range(0, 3);
      vl  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 700);
      if ($urandom_range(0, 7) == 0) vl = $urandom_range(2000, 6000);
      a = longint'($urandom) & ~((64'd1 << vew) - 1);
      run_cmd($urandom_range(0, 1), a, vl, vew);
    end
    run_cmd(0, 64'h5000, 8, 3);

    // Load is latched: a B retire is ignored, an R retire at zero credits is an error.
    b_valid_i = 1'b1; @(posedge clk_i); #1; b_valid_i = 1'b0;
    chk("err_other_kind", err_o, 0);
    r_last_i = 1'b1; @(posedge clk_i); #1; r_last_i = 1'b0;
    chk("err_set", err_o, 1);
    chk("err_cnt_zero", outstanding_o, 0);
    @(posedge clk_i); #1;
    chk("err_sticky", err_o, 1);

    // Reset while a burst is pending.
    cmd_valid_i = 1'b1; cmd_is_store_i = 1'b0; cmd_addr_i = 64'h0; cmd_vl_i = 16'd2048; cmd_vew_i = 2'd3;
    @(posedge clk_i); #1; cmd_valid_i = 1'b0;
    chk("pre_rst_valid", burst_valid_o, 1);
    rst_i = 1'b1; #1;
    chk("mid_rst_valid", burst_valid_o, 0);
    chk("mid_rst_ready", cmd_ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_addr", burst_addr_o, 0);
    @(posedge clk_i); #1;
    chk("mid_rst_done", cmd_done_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("post_rst_done", cmd_done_o, 0);
    chk("post_rst_outstanding", outstanding_o, 0);
    run_cmd(1, 64'h7FC0, 40, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
